// File: rtl/alu_seq_mul_pkg.sv
// alu_seq_mul_pkg: ALUControl op codes shared with the decoder.
package alu_seq_mul_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
endpackage

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: radix-2 shift-add multiplier, one partial product per step.
module seq_shift_add_mul #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             last
);
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    // product is the accumulator after the current step, so the final step's result is usable at once
    assign product = acc + (mplier[0] ? mcand : '0);
    assign last    = cnt == CNT_W'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CNT_W'(WIDTH);
        end else if (step && cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: execute-stage ALU with registered single-cycle ops and an iterative multiply.
module alu_seq_mul
    import alu_seq_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
    state_e state, state_next;
    logic accept, is_mul, last;
    logic [WIDTH-1:0] alu_res, product;
    assign is_mul = ALUControl == ALU_MUL;
    assign accept = Start && state != S_MUL;
    seq_shift_add_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk(CLK), .rst(RST), .load(accept && is_mul), .step(state == S_MUL),
        .a(SrcA), .b(SrcB), .product(product), .last(last)
    );
    always_comb begin
        alu_res = ALUControl == ALU_AND ? SrcA & SrcB :
                  ALUControl == ALU_OR  ? SrcA | SrcB :
                  ALUControl == ALU_SUB ? SrcA - SrcB :
                  ALUControl == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)} :
                                          SrcA + SrcB;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state == S_MUL ? (last ? S_DONE : S_MUL) :
                     accept         ? (is_mul ? S_MUL : S_DONE) : S_IDLE;
    end
    always_comb begin
        Busy = state == S_MUL;
        Done = state == S_DONE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else if (accept && !is_mul) begin
            ALUResult <= alu_res;
            Zero      <= alu_res == '0;
        end else if (state == S_MUL && last) begin
            ALUResult <= product;
            Zero      <= product == '0;
        end
    end
endmodule

// File: tb/tb_alu_seq_mul.sv
// tb_alu_seq_mul: random and directed checks of alu_seq_mul against a cycle-level reference model.
module tb_alu_seq_mul;
    localparam int W = 32;
    logic CLK = 0, RST = 0, Start = 0;
    logic [W-1:0] SrcA = '0, SrcB = '0;
    logic [2:0] ALUControl = '0;
    logic [W-1:0] ALUResult;
    logic Zero, Busy, Done;
    int errors = 0, checks = 0;

    alu_seq_mul #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .SrcA(SrcA), .SrcB(SrcB),
        .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b100:  return a - b;
            3'b110:  return ($signed(a) < $signed(b)) ? 1 : 0;
            3'b101:  return a * b;
            default: return a + b;
        endcase
    endfunction

    // Model: a multiply simply occupies the unit for W cycles, then its product appears.
    logic [W-1:0] m_res, m_pend;
    logic m_done, m_busy;
    int m_left;
    bit m_valid = 0;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_res <= '0; m_done <= 0; m_busy <= 0; m_left <= 0; m_valid <= 1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_busy <= m_left > 1;
            m_done <= m_left == 1;
            if (m_left == 1) m_res <= m_pend;
        end else if (Start && ALUControl == 3'b101) begin
            m_pend <= ref_op(ALUControl, SrcA, SrcB);
            m_left <= W; m_busy <= 1; m_done <= 0;
        end else if (Start) begin
            m_res <= ref_op(ALUControl, SrcA, SrcB); m_done <= 1;
        end else m_done <= 0;
    end

    always @(negedge CLK) if (m_valid) begin
        chk("result", ALUResult, m_res);
        chk("zero", Zero, m_res == '0);
        chk("busy", Busy, m_busy);
        chk("done", Done, m_done);
        chk("busy_done_excl", Busy && Done, 0);
    end

    task automatic drive(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        ALUControl = op; SrcA = a; SrcB = b; Start = 1;
    endtask

    task automatic run(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, output int cyc, output int nb);
        @(negedge CLK); drive(op, a, b);
        @(negedge CLK); Start = 0; cyc = 1; nb = Busy;
        while (!Done && cyc < 100) begin @(negedge CLK); cyc++; nb += Busy; end
        chk("done_seen", Done, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c, nb, t, nd;
        #1 RST = 1;
        #2;
        chk("rst_result", ALUResult, 0); chk("rst_zero", Zero, 1);
        chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
        @(negedge CLK); @(negedge CLK); RST = 0;
        run(3'b010, 5, 7, c, nb);
        chk("add_res", ALUResult, 12); chk("add_zero", Zero, 0); chk("add_lat", c, 1); chk("add_busy", nb, 0);
        run(3'b100, 7, 7, c, nb);
        chk("sub_res", ALUResult, 0); chk("sub_zero", Zero, 1);
        run(3'b110, 32'hFFFF_FFFF, 1, c, nb); chk("slt_neg", ALUResult, 1);
        run(3'b110, 1, 32'hFFFF_FFFF, c, nb); chk("slt_pos", ALUResult, 0);
        run(3'b010, 32'hFFFF_FFFF, 1, c, nb); chk("add_wrap", ALUResult, 0);
        run(3'b111, 3, 4, c, nb); chk("op111_add", ALUResult, 7);
        run(3'b101, 6, 7, c, nb);
        chk("mul_res", ALUResult, 42); chk("mul_lat", c, 33); chk("mul_busy", nb, 32);
        run(3'b101, 32'hFFFF_FFFD, 5, c, nb); chk("mul_neg", ALUResult, 32'hFFFF_FFF1);
        // Start during a multiply is dropped
        @(negedge CLK); drive(3'b101, 6, 7);
        @(negedge CLK); Start = 0; c = 1;
        repeat (5) begin @(negedge CLK); c++; end
        drive(3'b010, 1, 1);
        @(negedge CLK); Start = 0; SrcA = 99; SrcB = 3; c++;
        while (!Done && c < 100) begin @(negedge CLK); c++; end
        chk("ign_res", ALUResult, 42); chk("ign_lat", c, 33);
        nd = 0;
        repeat (5) begin @(negedge CLK); nd += Done; end
        chk("ign_extra_done", nd, 0);
        // Async reset mid-multiply
        @(negedge CLK); drive(3'b101, 9, 9);
        @(negedge CLK); Start = 0;
        repeat (9) @(negedge CLK);
        #2 RST = 1;
        #1;
        chk("amid_result", ALUResult, 0); chk("amid_zero", Zero, 1);
        chk("amid_busy", Busy, 0); chk("amid_done", Done, 0);
        @(posedge CLK); @(negedge CLK); RST = 0;
        nd = 0;
        repeat (40) begin @(negedge CLK); nd += Done; end
        chk("post_rst_done", nd, 0);
        run(3'b010, 2, 2, c, nb); chk("post_rst_add", ALUResult, 4);
        // Back-to-back issue from DONE
        @(negedge CLK); drive(3'b010, 1, 2);
        @(negedge CLK); t = 1;
        chk("b2b_add_done", Done, 1); chk("b2b_add", ALUResult, 3);
        drive(3'b101, 32'h1234, 32'h10);
        @(negedge CLK); Start = 0; t++;
        while (!Done && t < 200) begin @(negedge CLK); t++; end
        chk("b2b_mul_t", t, 34); chk("b2b_mul", ALUResult, 32'h12340);
        drive(3'b000, 32'hF0F0, 32'hFF00);
        @(negedge CLK); Start = 0; t++;
        chk("b2b_and_t", t, 35); chk("b2b_and_done", Done, 1); chk("b2b_and", ALUResult, 32'hF000);
        // Random traffic, including Start while busy
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            Start = $urandom_range(0, 2) != 0;
            ALUControl = 3'($urandom);
            SrcA = pick();
            SrcB = pick();
        end
        @(negedge CLK); Start = 0;
        repeat (40) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
